// File: rtl/l1_pkg.sv
// Shared definitions for the L1 write port.
// Provides default widths, the default-width BRAM write address layout and the
// per-stream occupancy next-value helper.
package l1_pkg;

    localparam int unsigned L1Nstrms = 64;
    localparam int unsigned L1Nports = 8;
    localparam int unsigned L1PtrW   = 4;
    localparam int unsigned L1SidW   = $clog2(L1Nstrms);
    localparam int unsigned L1CntW   = L1PtrW + 1;
    localparam int unsigned L1RelW   = $clog2(L1Nports + 1);

    // BRAM write address at default widths: stream id in the high bits, entry pointer low.
    typedef struct packed {
        logic [L1SidW-1:0] sid;
        logic [L1PtrW-1:0] ptr;
    } l1_wr_addr_t;

    // Unsaturated next occupancy; a negative result flags a release underflow.
    function automatic int cnt_next(input int cnt, input int inc, input int rel);
        return cnt + inc - rel;
    endfunction

endpackage

// File: rtl/l1_wr_strm_cnt.sv
// One stream's write pointer and occupancy counter.
// Ports:
//   clk, reset  clock, synchronous active-low reset
//   inc         one entry written to this stream this cycle
//   rel         entries released by the read ports this cycle
//   clr         stream reset: pointer and count to 0, release ignored
//   ptr         current write pointer
//   cnt         occupancy, 0..2**ptr_width
//   full        cnt == 2**ptr_width
//   underflow   release exceeded occupancy this cycle (count saturated at 0)
module l1_wr_strm_cnt
    import l1_pkg::*;
#(
    parameter int unsigned ptr_width = L1PtrW,
    parameter int unsigned rel_width = L1RelW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic [rel_width-1:0] rel,
    input  logic                 clr,
    output logic [ptr_width-1:0] ptr,
    output logic [ptr_width:0]   cnt,
    output logic                 full,
    output logic                 underflow
);

    localparam int unsigned CntW  = ptr_width + 1;
    localparam int          Depth = int'(2 ** ptr_width);

    logic [ptr_width-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    int                   sum;

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        underflow = 1'b0;
        sum       = cnt_next(int'(cnt_q), int'(inc), int'(rel));

        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + ptr_width'(1);   // wraps naturally at the stream depth
        end

        if (clr) begin
            cnt_d = '0;
        end else if (sum < 0) begin
            cnt_d     = '0;
            underflow = 1'b1;
        end else if (sum > Depth) begin
            cnt_d = CntW'(Depth);
        end else begin
            cnt_d = CntW'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign ptr  = ptr_q;
    assign cnt  = cnt_q;
    assign full = (cnt_q == CntW'(Depth));

endmodule

// File: rtl/l1_wr_port.sv
// L1 write port: fill side of the L1 stream buffers.
// Accepts one write per cycle into a one-entry stage, tags it with the stream's current
// write pointer and issues it as a BRAM write. Tracks per-stream pointer and occupancy;
// read ports hand back consumed entries through per-stream release counts.
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   i_wr_v/i_wr_r          write request handshake; i_wr_sid target stream, i_wr_d data
//   i_rel_cnt              per-stream release counts (rel_width each)
//   i_srst_v/i_srst_sid    stream reset strobe and target
//   o_wr_v/o_wr_r          BRAM write handshake; o_wr_addr = {sid, wptr}, o_wr_d data
//   o_cnt, o_full          per-stream occupancy and full flag
//   o_err                  only with L1_WR_ERR_EN: sticky release-underflow / stream-reset
//                          of a pending write, cleared by reset
module l1_wr_port
    import l1_pkg::*;
#(
    parameter int unsigned nstrms     = 64,
    parameter int unsigned sid_width  = $clog2(nstrms),
    parameter int unsigned nports     = 8,
    parameter int unsigned ptr_width  = 4,
    parameter int unsigned data_width = 64,
    parameter int unsigned rel_width  = $clog2(nports + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_wr_v,
    output logic                              i_wr_r,
    input  logic [sid_width-1:0]              i_wr_sid,
    input  logic [data_width-1:0]             i_wr_d,
    input  logic [nstrms*rel_width-1:0]       i_rel_cnt,
    input  logic                              i_srst_v,
    input  logic [sid_width-1:0]              i_srst_sid,
    output logic                              o_wr_v,
    input  logic                              o_wr_r,
    output logic [sid_width+ptr_width-1:0]    o_wr_addr,
    output logic [data_width-1:0]             o_wr_d,
    output logic [nstrms*(ptr_width+1)-1:0]   o_cnt,
    output logic [nstrms-1:0]                 o_full
`ifdef L1_WR_ERR_EN
    ,
    output logic                              o_err
`endif
);

    localparam int unsigned CntW = ptr_width + 1;

    // Same layout as l1_wr_addr_t, sized by this instance's parameters.
    typedef struct packed {
        logic [sid_width-1:0] sid;
        logic [ptr_width-1:0] ptr;
    } wr_addr_t;

    logic                  s1_v_q;
    logic [sid_width-1:0]  s1_sid_q;
    logic [data_width-1:0] s1_d_q;

    logic                  accept;
    logic                  wr_fire;
    logic [nstrms-1:0]     inc;
    logic [nstrms-1:0]     clr;
    logic [ptr_width-1:0]  wptr [nstrms];
    logic [CntW-1:0]       cnt  [nstrms];
    wr_addr_t              addr;

    // A full target stream holds the stage, which blocks every later write in order.
    always_comb begin
        o_wr_v  = s1_v_q & ~o_full[s1_sid_q] & ~i_srst_v;
        wr_fire = o_wr_v & o_wr_r;
        i_wr_r  = ~s1_v_q | wr_fire;
        accept  = i_wr_v & i_wr_r;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_q   <= 1'b0;
            s1_sid_q <= '0;
            s1_d_q   <= '0;
        end else if (accept) begin
            s1_v_q   <= 1'b1;
            s1_sid_q <= i_wr_sid;
            s1_d_q   <= i_wr_d;
        end else if (wr_fire) begin
            s1_v_q   <= 1'b0;
        end
    end

    assign addr.sid  = s1_sid_q;
    assign addr.ptr  = wptr[s1_sid_q];
    assign o_wr_addr = addr;
    assign o_wr_d    = s1_d_q;

`ifdef L1_WR_ERR_EN
    logic [nstrms-1:0] underflow;
    logic              srst_hit;
    logic              err_q;

    assign srst_hit = i_srst_v & s1_v_q & (s1_sid_q == i_srst_sid);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((|underflow) | srst_hit) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`endif

    for (genvar s = 0; s < nstrms; s++) begin : g_strm
        assign inc[s] = wr_fire & (s1_sid_q == sid_width'(s));
        assign clr[s] = i_srst_v & (i_srst_sid == sid_width'(s));

        l1_wr_strm_cnt #(
            .ptr_width (ptr_width),
            .rel_width (rel_width)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc[s]),
            .rel       (i_rel_cnt[s*rel_width +: rel_width]),
            .clr       (clr[s]),
            .ptr       (wptr[s]),
            .cnt       (cnt[s]),
            .full      (o_full[s]),
`ifdef L1_WR_ERR_EN
            .underflow (underflow[s])
`else
            .underflow ()
`endif
        );

        assign o_cnt[s*CntW +: CntW] = cnt[s];
    end

endmodule
